// File: rtl/add_csa_pkg.sv
// Shared sizing helpers for the carry-save adder tree: level count, rows per
// level and output width, all usable in constant expressions.
package add_csa_pkg;

  localparam int MaxLevels = 32;

  function automatic int csa_next(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int csa_rows(input int ops, input int lvl);
    int n = ops;
    for (int i = 0; i < lvl; i++) n = csa_next(n);
    return n;
  endfunction

  function automatic int csa_levels(input int ops);
    int n = ops;
    int l = 0;
    for (int i = 0; i < MaxLevels; i++) begin
      if (n > 2) begin
        n = csa_next(n);
        l++;
      end
    end
    return l;
  endfunction

  function automatic int csa_out_bits(input int bits, input int ops);
    return bits + $clog2(ops);
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// One row of full adders: three vectors in, sum and unshifted carry out.
module csa_3to2 #(
  parameter int Bits = 8
) (
  input  logic [Bits-1:0] a,
  input  logic [Bits-1:0] b,
  input  logic [Bits-1:0] c,
  output logic [Bits-1:0] sum,
  output logic [Bits-1:0] carry
);
  for (genvar i = 0; i < Bits; i++) begin : g_bit
    full_adder u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(c[i]),
      .s (sum[i]),
      .co(carry[i])
    );
  end
endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the cell of every 3:2 compressor row.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/add_csa_tree_pipe.sv
// Streaming multi-operand adder: input register, one registered 3:2 level per
// tree stage, final carry-propagate add into the output register.
module add_csa_tree_pipe
  import add_csa_pkg::*;
#(
  parameter int Bits    = 64,
  parameter int Ops     = 8,
  parameter int Signed  = 0,
  parameter int TagBits = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [Ops*Bits-1:0]                in_ops,
  input  logic [TagBits-1:0]                 in_tag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [csa_out_bits(Bits, Ops)-1:0] out_sum,
  output logic [TagBits-1:0]                 out_tag
);

  localparam int OutBits = csa_out_bits(Bits, Ops);
  localparam int L       = csa_levels(Ops);
  localparam int NStg    = L + 2;
  localparam int ExtBits = OutBits - Bits;

  logic                             advance;
  logic [NStg-1:0]                  vld_q;
  logic [NStg-1:0][TagBits-1:0]     tag_q;
  logic [Ops-1:0][OutBits-1:0]      ext, ops_q;
  logic [OutBits-1:0]               sum_q;

  // Whole-pipe stall: nothing moves unless the output slot is free or draining.
  assign advance   = !vld_q[NStg-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[NStg-1];
  assign out_sum   = sum_q;
  assign out_tag   = tag_q[NStg-1];

  for (genvar k = 0; k < Ops; k++) begin : g_ext
    logic [Bits-1:0] op;
    assign op     = in_ops[k*Bits +: Bits];
    assign ext[k] = {{ExtBits{(Signed != 0) & op[Bits-1]}}, op};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      tag_q <= '0;
    end else if (advance) begin
      vld_q <= {vld_q[NStg-2:0], in_valid};
      tag_q <= {tag_q[NStg-2:0], in_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (advance) ops_q <= ext;
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int NIn  = csa_rows(Ops, l);
    localparam int NOut = csa_rows(Ops, l + 1);
    localparam int NTri = NIn / 3;

    logic [NIn-1:0][OutBits-1:0]  rin;
    logic [NOut-1:0][OutBits-1:0] nxt, rows_q;

    if (l == 0) begin : g_src
      assign rin = ops_q;
    end else begin : g_src
      assign rin = g_lvl[l-1].rows_q;
    end

    for (genvar t = 0; t < NTri; t++) begin : g_tri
      logic [OutBits-1:0] cy;
      logic               unused_cy_msb;
      csa_3to2 #(.Bits(OutBits)) u_csa (
        .a    (rin[3*t]),
        .b    (rin[3*t+1]),
        .c    (rin[3*t+2]),
        .sum  (nxt[2*t]),
        .carry(cy)
      );
      // Carry weight is one bit up; the top carry falls outside the modulus.
      assign nxt[2*t+1]    = {cy[OutBits-2:0], 1'b0};
      assign unused_cy_msb = cy[OutBits-1];
    end

    for (genvar p = 0; p < NIn - 3*NTri; p++) begin : g_pass
      assign nxt[2*NTri+p] = rin[3*NTri+p];
    end

    always_ff @(posedge clk) begin
      if (advance) rows_q <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else if (advance) sum_q <= g_lvl[L-1].rows_q[0] + g_lvl[L-1].rows_q[1];
  end

endmodule

// File: tb/tb_add_csa_tree_pipe.sv
// Bench: 8x8 unsigned and signed instances share stimulus, a 3x64 instance
// covers the minimum operand count; results checked through a scoreboard.
module tb_add_csa_tree_pipe;

  localparam int LAT8 = 5;
  localparam int LATC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, b_in_ready, a_out_ready;
  logic        a_out_valid, b_out_valid;
  logic [63:0] a_in_ops;
  logic [3:0]  a_in_tag, a_out_tag, b_out_tag;
  logic [10:0] a_out_sum, b_out_sum;

  logic         c_in_valid, c_in_ready, c_out_ready, c_out_valid;
  logic [191:0] c_in_ops;
  logic [3:0]   c_in_tag, c_out_tag;
  logic [65:0]  c_out_sum;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [63:0] ops; logic [3:0] tag; } stim_t;
  typedef struct { logic [10:0] su; logic [10:0] ss; logic [3:0] tag; } exp_t;
  stim_t stim[$];
  exp_t  sb[$];
  logic  vh[4096];

  add_csa_tree_pipe #(.Bits(8), .Ops(8), .Signed(0), .TagBits(4)) u_dut_u (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ops(a_in_ops), .in_tag(a_in_tag), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_sum(a_out_sum), .out_tag(a_out_tag)
  );

  add_csa_tree_pipe #(.Bits(8), .Ops(8), .Signed(1), .TagBits(4)) u_dut_s (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(b_in_ready),
    .in_ops(a_in_ops), .in_tag(a_in_tag), .out_valid(b_out_valid),
    .out_ready(a_out_ready), .out_sum(b_out_sum), .out_tag(b_out_tag)
  );

  add_csa_tree_pipe #(.Bits(64), .Ops(3), .Signed(0), .TagBits(4)) u_dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_ops(c_in_ops), .in_tag(c_in_tag), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_sum(c_out_sum), .out_tag(c_out_tag)
  );

  function automatic exp_t model(input stim_t s);
    exp_t e;
    int su = 0;
    int ss = 0;
    for (int k = 0; k < 8; k++) begin
      su += int'(s.ops[k*8 +: 8]);
      ss += int'($signed(s.ops[k*8 +: 8]));
    end
    e.su  = su[10:0];
    e.ss  = ss[10:0];
    e.tag = s.tag;
    return e;
  endfunction

  // Drives queued stimulus, checks handshake, hold and scoreboard every cycle.
  task automatic pump(input bit alt, input bit rnd);
    int   cyc   = 0;
    bit   held  = 0;
    bit   phase = 1;
    logic [10:0] hs;
    logic [3:0]  ht;
    exp_t e;
    while ((stim.size() > 0 || sb.size() > 0) && cyc < 3000) begin
      a_in_valid = (stim.size() > 0) && (!alt || phase);
      if (stim.size() > 0) begin
        a_in_ops = stim[0].ops;
        a_in_tag = stim[0].tag;
      end
      a_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      vh[cyc] = a_in_valid;
      total++;
      if (a_in_ready !== (!a_out_valid || a_out_ready) || b_in_ready !== a_in_ready) begin
        bad++;
        $display("FAIL in_ready cyc=%0d got=%b/%b want=%b", cyc, a_in_ready, b_in_ready, !a_out_valid || a_out_ready);
      end
      if (held) begin
        total++;
        if (a_out_valid !== 1'b1 || a_out_sum !== hs || a_out_tag !== ht) begin
          bad++;
          $display("FAIL hold cyc=%0d got=%b/%h/%h want=1/%h/%h", cyc, a_out_valid, a_out_sum, a_out_tag, hs, ht);
        end
      end
      if (alt && cyc > LAT8) begin
        total++;
        if (a_out_valid !== vh[cyc-LAT8-1]) begin
          bad++;
          $display("FAIL bubble_pattern cyc=%0d got=%b want=%b", cyc, a_out_valid, vh[cyc-LAT8-1]);
        end
      end
      if (a_out_valid === 1'b1 && a_out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_output cyc=%0d got sum=%h want none", cyc, a_out_sum);
        end else begin
          e = sb.pop_front();
          if (a_out_sum !== e.su || a_out_tag !== e.tag) begin
            bad++;
            $display("FAIL unsigned_result cyc=%0d got=%h/%h want=%h/%h", cyc, a_out_sum, a_out_tag, e.su, e.tag);
          end
          total++;
          if (b_out_valid !== 1'b1 || b_out_sum !== e.ss || b_out_tag !== e.tag) begin
            bad++;
            $display("FAIL signed_result cyc=%0d got=%b/%h/%h want=1/%h/%h", cyc, b_out_valid, b_out_sum, b_out_tag, e.ss, e.tag);
          end
        end
      end
      held = (a_out_valid === 1'b1) && !a_out_ready;
      hs = a_out_sum;
      ht = a_out_tag;
      if (a_in_valid && a_in_ready) begin
        sb.push_back(model(stim[0]));
        void'(stim.pop_front());
      end
      phase = !phase;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 3000) begin
      total++; bad++;
      $display("FAIL pump_timeout got pending=%0d/%0d want 0/0", stim.size(), sb.size());
      stim.delete(); sb.delete();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_ops = '0; a_in_tag = '0; a_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_ops = '0; c_in_tag = '0; c_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total += 4;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b/%b want=0", a_out_valid, b_out_valid); end
    if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready); end
    if (a_out_sum !== '0 || a_out_tag !== '0) begin bad++; $display("FAIL reset_out got=%h/%h want=0/0", a_out_sum, a_out_tag); end
    if (c_out_valid !== 1'b0 || c_out_sum !== '0 || c_in_ready !== 1'b1) begin bad++; $display("FAIL reset_c got=%b/%h/%b want=0/0/1", c_out_valid, c_out_sum, c_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    int n;
    a_in_ops = {8{8'hFF}}; a_in_tag = 4'd3; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (a_in_ready !== 1'b1) begin bad++; $display("FAIL ones_accept got=%b want=1", a_in_ready); end
    @(posedge clk); #1 a_in_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); n++; @(negedge clk); end while (a_out_valid !== 1'b1 && n < 20);
    total += 3;
    if (n != LAT8) begin bad++; $display("FAIL ones_latency got=%0d want=%0d", n, LAT8); end
    if (a_out_sum !== 11'h7F8 || a_out_tag !== 4'd3) begin bad++; $display("FAIL ones_unsigned got=%h/%h want=7f8/3", a_out_sum, a_out_tag); end
    if (b_out_valid !== 1'b1 || b_out_sum !== 11'h7F8) begin bad++; $display("FAIL ones_signed got=%b/%h want=1/7f8", b_out_valid, b_out_sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    stim_t s;
    logic [7:0] v [8] = '{8'd1, 8'hFF, 8'd2, 8'hFE, 8'd3, 8'hFD, 8'd4, 8'hFC};
    s.ops = {8{8'h80}}; s.tag = 4'd7;
    stim.push_back(s);
    for (int k = 0; k < 8; k++) s.ops[k*8 +: 8] = v[k];
    s.tag = 4'd8;
    stim.push_back(s);
    pump(1'b0, 1'b0);
  endtask

  task automatic test_min_ops();
    logic [65:0] want [2] = '{66'h1_0000_0000_0000_0001, 66'h2_FFFF_FFFF_FFFF_FFFD};
    logic [191:0] ops [2] = '{{64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF}, {3{64'hFFFF_FFFF_FFFF_FFFF}}};
    int n;
    for (int i = 0; i < 2; i++) begin
      c_in_ops = ops[i]; c_in_tag = 4'(5 + i); c_in_valid = 1'b1;
      @(posedge clk); #1 c_in_valid = 1'b0;
      n = 0;
      do begin @(posedge clk); n++; @(negedge clk); end while (c_out_valid !== 1'b1 && n < 20);
      total += 2;
      if (n != LATC) begin bad++; $display("FAIL minops_latency%0d got=%0d want=%0d", i, n, LATC); end
      if (c_out_sum !== want[i] || c_out_tag !== 4'(5 + i)) begin bad++; $display("FAIL minops_sum%0d got=%h/%h want=%h/%h", i, c_out_sum, c_out_tag, want[i], 4'(5 + i)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    stim_t s;
    for (int i = 0; i < 100; i++) begin
      s.ops = {$urandom, $urandom};
      s.tag = 4'(i % 16);
      stim.push_back(s);
    end
    pump(1'b0, 1'b1);
  endtask

  task automatic test_reset_midstream();
    int n;
    int seen = 0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_ops = {8{8'(i + 1)}}; a_in_tag = 4'(9 + i);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (a_out_valid !== 1'b0 || a_out_sum !== '0 || a_out_tag !== '0) begin
      bad++; $display("FAIL midreset_out got=%b/%h/%h want=0/0/0", a_out_valid, a_out_sum, a_out_tag);
    end
    repeat (10) begin @(negedge clk); if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL midreset_ghost got=%0d want=0", seen); end
    @(posedge clk); #1;
    a_in_ops = {8{8'h11}}; a_in_tag = 4'hA; a_in_valid = 1'b1;
    @(posedge clk); #1 a_in_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); n++; @(negedge clk); end while (a_out_valid !== 1'b1 && n < 20);
    total += 2;
    if (n != LAT8) begin bad++; $display("FAIL midreset_latency got=%0d want=%0d", n, LAT8); end
    if (a_out_sum !== 11'h088 || a_out_tag !== 4'hA) begin bad++; $display("FAIL midreset_sum got=%h/%h want=088/a", a_out_sum, a_out_tag); end
    @(posedge clk); #1;
  endtask

  task automatic test_bubbles();
    stim_t s;
    for (int i = 0; i < 12; i++) begin
      s.ops = {$urandom, $urandom};
      s.tag = 4'(15 - i);
      stim.push_back(s);
    end
    pump(1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_ones();
    test_signed();
    test_min_ops();
    test_backpressure();
    test_reset_midstream();
    test_bubbles();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
